// File: rtl/meas_seq_pkg.sv
// Shared types and constants for the Q-control measurement sequencer.
//   seq_state_t : sequencer FSM states
//   ERR_*       : err_code values reported by meas_ctrl_sequencer
package meas_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        MEASURE,
        EVAL,
        GAP,
        LOCKED,
        FAULT
    } seq_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_NOCONV   = 2'd2;
    localparam logic [1:0] ERR_UNSTABLE = 2'd3;

endpackage

// File: rtl/seq_watchdog.sv
// Clear/enable up-counter with terminal-count flag.
// Used both as the measurement watchdog and as the inter-evaluation gap timer.
//   clk : clock
//   rst : synchronous active-high reset
//   clr : synchronous clear to 0 (wins over en)
//   en  : count one step per cycle; holds once terminal count is reached
//   tc  : high while the count equals TIMEOUT_CYCLES-1
module seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] TERM = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && cnt != TERM)
            cnt <= cnt + W'(1);
    end

    assign tc = (cnt == TERM);

endmodule

// File: rtl/meas_ctrl_sequencer.sv
// Q-control loop sequencer: pulses start to the Q measurement block, waits for
// ready under a watchdog, strobes the bisection/i_ref update, and declares lock
// after SETTLE_COUNT consecutive in-tolerance evaluations.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   run              : level, 1 = operate the loop, 0 = return to IDLE
//   q_desired        : target Q
//   q_measured,ready : measurement result and its done strobe
//   went_unstable    : instability flag from bisection
//   start            : one-cycle pulse to q_measurement
//   ctrl_enable      : one-cycle update strobe to bisection/i_ref_sampling
//   busy, locked     : status
//   err_code         : 0 none, 1 timeout, 2 no convergence, 3 unstable (sticky)
//   iter_count       : evaluations in current lock attempt
// Build option: define SEQ_TRACK_EN to re-measure periodically while LOCKED.
module meas_ctrl_sequencer
    import meas_seq_pkg::*;
#(
    parameter int BUS_WIDTH      = 10,
    parameter int TOL            = 1,
    parameter int SETTLE_COUNT   = 4,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int GAP_CYCLES     = 2,
    parameter int MAX_ITER       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic [BUS_WIDTH-1:0]          q_desired,
    input  logic [BUS_WIDTH-1:0]          q_measured,
    input  logic                          ready,
    input  logic                          went_unstable,
    output logic                          start,
    output logic                          ctrl_enable,
    output logic                          busy,
    output logic                          locked,
    output logic [1:0]                    err_code,
    output logic [$clog2(MAX_ITER+1)-1:0] iter_count
);

    localparam int ITW    = $clog2(MAX_ITER + 1);
    localparam int TCW    = $clog2(SETTLE_COUNT + 1);
    localparam int GAP_WD = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
    localparam logic [ITW-1:0]     MAX_IT_V = ITW'(MAX_ITER);
    localparam logic [TCW-1:0]     SETTLE_V = TCW'(SETTLE_COUNT);
    localparam logic [BUS_WIDTH:0] TOL_V    = (BUS_WIDTH + 1)'(TOL);

    seq_state_t           state;
    logic [BUS_WIDTH-1:0] q_des_r, q_meas_r;
    logic [TCW-1:0]       tol_cnt, tol_nxt;
    logic [ITW-1:0]       iter_nxt;
    logic                 wd_en, wd_tc, gap_clr, gap_en, gap_tc, gap_done, eval_ok;

    // |a - b| in one extra signed bit so the full unsigned range cannot overflow.
    function automatic logic within_tol(input logic [BUS_WIDTH-1:0] a,
                                        input logic [BUS_WIDTH-1:0] b);
        logic signed [BUS_WIDTH:0] d;
        logic        [BUS_WIDTH:0] m;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        m = d[BUS_WIDTH] ? $unsigned(-d) : $unsigned(d);
        return (m <= TOL_V);
    endfunction

    assign eval_ok  = within_tol(q_des_r, q_meas_r);
    assign tol_nxt  = eval_ok ? tol_cnt + TCW'(1) : '0;
    assign iter_nxt = (iter_count == MAX_IT_V) ? iter_count : iter_count + ITW'(1);
    assign gap_done = (GAP_CYCLES == 0) || gap_tc;

`ifdef SEQ_TRACK_EN
    // 0: waiting out the gap in LOCKED, 1: tracking measurement in flight
    logic trk_meas;
    assign wd_en   = (state == MEASURE) || (state == LOCKED && trk_meas && !start);
    assign gap_clr = (state == EVAL) || (state == LOCKED && trk_meas);
    assign gap_en  = (state == GAP) || (state == LOCKED && !trk_meas);
`else
    assign wd_en   = (state == MEASURE);
    assign gap_clr = (state == EVAL);
    assign gap_en  = (state == GAP);
`endif

    // start is registered and high exactly in the cycle before measurement,
    // so it doubles as the watchdog clear.
    seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk(clk), .rst(rst), .clr(start), .en(wd_en), .tc(wd_tc)
    );

    seq_watchdog #(.TIMEOUT_CYCLES(GAP_WD)) u_gap (
        .clk(clk), .rst(rst), .clr(gap_clr), .en(gap_en), .tc(gap_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            start       <= 1'b0;
            ctrl_enable <= 1'b0;
            busy        <= 1'b0;
            locked      <= 1'b0;
            err_code    <= ERR_NONE;
            iter_count  <= '0;
            tol_cnt     <= '0;
            q_des_r     <= '0;
            q_meas_r    <= '0;
`ifdef SEQ_TRACK_EN
            trk_meas    <= 1'b0;
`endif
        end else begin
            start       <= 1'b0;
            ctrl_enable <= 1'b0;
            if (!run) begin
                state      <= IDLE;
                busy       <= 1'b0;
                locked     <= 1'b0;
                err_code   <= ERR_NONE;
                iter_count <= '0;
                tol_cnt    <= '0;
            end else if (went_unstable && state != IDLE && state != FAULT) begin
                state    <= FAULT;
                busy     <= 1'b0;
                locked   <= 1'b0;
                err_code <= ERR_UNSTABLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= START;
                        start <= 1'b1;
                        busy  <= 1'b1;
                    end
                    START: begin
                        q_des_r <= q_desired;
                        state   <= MEASURE;
                    end
                    MEASURE: begin
                        // ready beats a simultaneous watchdog terminal count
                        if (ready) begin
                            q_meas_r    <= q_measured;
                            state       <= EVAL;
                            ctrl_enable <= 1'b1;
                        end else if (wd_tc) begin
                            state    <= FAULT;
                            busy     <= 1'b0;
                            err_code <= ERR_TIMEOUT;
                        end
                    end
                    EVAL: begin
                        tol_cnt    <= tol_nxt;
                        iter_count <= iter_nxt;
                        if (tol_nxt == SETTLE_V) begin
                            state  <= LOCKED;
                            busy   <= 1'b0;
                            locked <= 1'b1;
`ifdef SEQ_TRACK_EN
                            trk_meas <= 1'b0;
`endif
                        end else if (iter_nxt == MAX_IT_V) begin
                            state    <= FAULT;
                            busy     <= 1'b0;
                            err_code <= ERR_NOCONV;
                        end else if (GAP_CYCLES == 0) begin
                            state <= START;
                            start <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end
                    GAP: begin
                        if (gap_done) begin
                            state <= START;
                            start <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (q_desired != q_des_r) begin
                            state      <= START;
                            start      <= 1'b1;
                            busy       <= 1'b1;
                            locked     <= 1'b0;
                            iter_count <= '0;
                            tol_cnt    <= '0;
                        end
`ifdef SEQ_TRACK_EN
                        else if (!trk_meas) begin
                            if (gap_done) begin
                                start    <= 1'b1;
                                trk_meas <= 1'b1;
                            end
                        end else if (!start) begin
                            if (ready) begin
                                q_meas_r <= q_measured;
                                trk_meas <= 1'b0;
                                if (!within_tol(q_des_r, q_measured)) begin
                                    state      <= START;
                                    start      <= 1'b1;
                                    busy       <= 1'b1;
                                    locked     <= 1'b0;
                                    iter_count <= '0;
                                    tol_cnt    <= '0;
                                end
                            end else if (wd_tc) begin
                                state    <= FAULT;
                                locked   <= 1'b0;
                                err_code <= ERR_TIMEOUT;
                            end
                        end
`endif
                    end
                    FAULT: begin
                        // held until run drops
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_meas_ctrl_sequencer.sv
module tb_meas_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       rst, run, ready, went_unstable;
    logic [9:0] q_desired, q_measured;
    logic       start, ctrl_enable, busy, locked;
    logic [1:0] err_code;
    logic [2:0] iter_count;

    int total = 0;
    int bad   = 0;
    int n_start = 0;
    int n_ctrl  = 0;
    int exp_q[$];

    typedef struct {
        logic [9:0] qd;
        logic [9:0] qm;
        int         exp_locked;
        int         exp_err;
        int         exp_iter;
    } vec_t;
    vec_t vecs[8];

    meas_ctrl_sequencer #(
        .BUS_WIDTH(10), .TOL(1), .SETTLE_COUNT(4),
        .TIMEOUT_CYCLES(8), .GAP_CYCLES(2), .MAX_ITER(5)
    ) dut (
        .clk(clk), .rst(rst), .run(run),
        .q_desired(q_desired), .q_measured(q_measured),
        .ready(ready), .went_unstable(went_unstable),
        .start(start), .ctrl_enable(ctrl_enable),
        .busy(busy), .locked(locked),
        .err_code(err_code), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle: sample outputs at the falling edge, count pulses and pop the
    // scoreboard whenever an update strobe appears.
    task automatic tick();
        @(negedge clk);
        if (start === 1'b1) n_start++;
        if (ctrl_enable === 1'b1) begin
            n_ctrl++;
            check("ctrl_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("eval_iter", int'(iter_count), exp_q.pop_front());
        end
    endtask

    task automatic wait_start(input int bound, output bit found);
        found = 0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (start === 1'b1) begin
                found = 1;
                break;
            end
        end
    endtask

    // Return a measurement lat cycles after the start pulse; expected
    // iter_count during the resulting update strobe goes on the scoreboard.
    task automatic respond(input logic [9:0] qm, input int lat, input int exp_iter);
        for (int i = 0; i < lat; i++) tick();
        ready = 1'b1;
        q_measured = qm;
        exp_q.push_back(exp_iter);
        tick();
        ready = 1'b0;
    endtask

    initial begin
        bit found;
        int s0, c0;

        vecs[0] = '{qd: 10'd500,  qm: 10'd499,  exp_locked: 1, exp_err: 0, exp_iter: 4};
        vecs[1] = '{qd: 10'd500,  qm: 10'd501,  exp_locked: 1, exp_err: 0, exp_iter: 4};
        vecs[2] = '{qd: 10'd500,  qm: 10'd502,  exp_locked: 0, exp_err: 2, exp_iter: 5};
        vecs[3] = '{qd: 10'd500,  qm: 10'd498,  exp_locked: 0, exp_err: 2, exp_iter: 5};
        vecs[4] = '{qd: 10'd0,    qm: 10'd1,    exp_locked: 1, exp_err: 0, exp_iter: 4};
        vecs[5] = '{qd: 10'd1023, qm: 10'd0,    exp_locked: 0, exp_err: 2, exp_iter: 5};
        vecs[6] = '{qd: 10'd0,    qm: 10'd1023, exp_locked: 0, exp_err: 2, exp_iter: 5};
        vecs[7] = '{qd: 10'd1023, qm: 10'd1022, exp_locked: 1, exp_err: 0, exp_iter: 4};

        // reset overrides run
        rst = 1'b1; run = 1'b1; ready = 1'b0; went_unstable = 1'b0;
        q_desired = 10'd500; q_measured = 10'd0;
        tick(); tick(); tick();
        check("rst_start", int'(start), 0);
        check("rst_ctrl", int'(ctrl_enable), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_err", int'(err_code), 0);
        check("rst_iter", int'(iter_count), 0);
        rst = 1'b0;

        // lock at 500 with 499/500/501/500, ready pulses outside MEASURE ignored
        s0 = n_start; c0 = n_ctrl;
        wait_start(10, found); check("lock_start0", int'(found), 1);
        respond(10'd499, 1, 0);
        ready = 1'b1; tick(); tick(); ready = 1'b0;
        wait_start(10, found); check("lock_start1", int'(found), 1);
        respond(10'd500, 2, 1);
        wait_start(10, found); check("lock_start2", int'(found), 1);
        respond(10'd501, 3, 2);
        wait_start(10, found); check("lock_start3", int'(found), 1);
        respond(10'd500, 1, 3);
        tick();
        check("lock_locked", int'(locked), 1);
        check("lock_iter", int'(iter_count), 4);
        check("lock_busy", int'(busy), 0);
        check("lock_nstart", n_start - s0, 4);
        check("lock_nctrl", n_ctrl - c0, 4);
        s0 = n_start;
        repeat (10) tick();
        check("lock_static_start", n_start - s0, 0);
        check("lock_static_locked", int'(locked), 1);

        // retarget to 300
        q_desired = 10'd300;
        tick();
        check("retgt_locked", int'(locked), 0);
        check("retgt_start", int'(start), 1);
        check("retgt_iter", int'(iter_count), 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                wait_start(10, found); check("retgt_start_n", int'(found), 1);
            end
            respond(10'd300, 2, i);
        end
        tick();
        check("retgt_relock", int'(locked), 1);
        check("retgt_iter4", int'(iter_count), 4);

        run = 1'b0;
        tick();
        check("idle_busy", int'(busy), 0);
        check("idle_locked", int'(locked), 0);

        // table: constant measurement per attempt, tolerance edges and extremes
        for (int v = 0; v < 8; v++) begin
            run = 1'b0; tick();
            q_desired = vecs[v].qd;
            run = 1'b1;
            for (int i = 0; i < vecs[v].exp_iter; i++) begin
                wait_start(20, found); check("tbl_start", int'(found), 1);
                respond(vecs[v].qm, 1 + (i % 3), i);
            end
            tick();
            check("tbl_locked", int'(locked), vecs[v].exp_locked);
            check("tbl_err", int'(err_code), vecs[v].exp_err);
            check("tbl_iter", int'(iter_count), vecs[v].exp_iter);
            s0 = n_start;
            repeat (10) tick();
            check("tbl_no_extra_start", n_start - s0, 0);
        end
        run = 1'b0; tick();

        // watchdog: eight MEASURE cycles without ready, then timeout fault
        q_desired = 10'd500;
        run = 1'b1;
        wait_start(10, found); check("to_start", int'(found), 1);
        repeat (8) tick();
        check("to_busy_before", int'(busy), 1);
        check("to_err_before", int'(err_code), 0);
        tick();
        check("to_err", int'(err_code), 1);
        check("to_busy", int'(busy), 0);
        run = 1'b0; tick();
        check("to_clr_err", int'(err_code), 0);

        // ready in the watchdog terminal cycle wins
        run = 1'b1;
        wait_start(10, found); check("bnd_start", int'(found), 1);
        respond(10'd100, 8, 0);
        check("bnd_err", int'(err_code), 0);
        check("bnd_busy", int'(busy), 1);
        // instability during GAP
        tick();
        went_unstable = 1'b1;
        tick();
        went_unstable = 1'b0;
        check("unst_err", int'(err_code), 3);
        check("unst_busy", int'(busy), 0);
        s0 = n_start;
        repeat (4) tick();
        check("unst_sticky", int'(err_code), 3);
        check("unst_no_start", n_start - s0, 0);
        run = 1'b0; tick();
        check("unst_clr", int'(err_code), 0);

        // run=0 beats went_unstable
        run = 1'b1;
        wait_start(10, found); check("pri_start", int'(found), 1);
        tick();
        run = 1'b0; went_unstable = 1'b1;
        tick();
        went_unstable = 1'b0;
        check("pri_err", int'(err_code), 0);
        check("pri_busy", int'(busy), 0);
        check("pri_start_low", int'(start), 0);

        // reset in the middle of MEASURE
        run = 1'b1;
        wait_start(10, found); check("mrst_start", int'(found), 1);
        respond(10'd100, 1, 0);
        wait_start(10, found); check("mrst_start2", int'(found), 1);
        tick();
        rst = 1'b1;
        tick();
        check("mrst_busy", int'(busy), 0);
        check("mrst_iter", int'(iter_count), 0);
        check("mrst_start_low", int'(start), 0);
        check("mrst_ctrl", int'(ctrl_enable), 0);
        check("mrst_err", int'(err_code), 0);
        check("mrst_locked", int'(locked), 0);
        rst = 1'b0; run = 1'b0;
        tick();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/meas_ctrl_sequencer.md
Name: meas_ctrl_sequencer

Overview:
Sequences the Q-control loop. Issues start pulses to the Q measurement block, waits for its ready (with watchdog), strobes the bisection/i_ref sampling update, and declares lock after consecutive in-tolerance measurements. Reports faults: timeout, no convergence, instability. Sits in top between q_measurement and bisection/i_ref_sampling; its ctrl_enable drives their enable.

Parameters:
BUS_WIDTH, 10, width of q_desired/q_measured.
TOL, 1, max |q_desired - q_measured| counted as in tolerance.
SETTLE_COUNT, 4, consecutive in-tolerance evaluations required for lock (>=1).
TIMEOUT_CYCLES, 1023, max cycles in MEASURE without ready before fault (>=2).
GAP_CYCLES, 2, idle cycles between evaluation and next start (i_ref settling; 0 allowed).
MAX_ITER, 32, max evaluations per lock attempt before no-convergence fault.

Ports:
clk  in  1  clock; single clock domain, all logic rising edge.
rst  in  1  synchronous, active-high reset.
run  in  1  level; 1 = operate loop, 0 = return to IDLE.
q_desired  in  BUS_WIDTH  target Q.
q_measured  in  BUS_WIDTH  from q_measurement; valid when ready=1.
ready  in  1  measurement done strobe.
went_unstable  in  1  from bisection.
start  out  1  one-cycle pulse to q_measurement.
ctrl_enable  out  1  one-cycle update strobe to bisection/i_ref_sampling.
busy  out  1  1 in any state except IDLE, LOCKED, FAULT.
locked  out  1  1 only in LOCKED.
err_code  out  2  0 none, 1 timeout, 2 no convergence, 3 unstable; sticky in FAULT.
iter_count  out  $clog2(MAX_ITER+1)  evaluations in current attempt.

Behaviour:
- Reset: state IDLE; all outputs 0; counters, latched q_desired, q_measured capture cleared. rst overrides run.
- IDLE: run=1 -> START; iter_count, in-tolerance counter cleared.
- START: start=1 for exactly this cycle; q_desired latched to q_des_r; watchdog cleared -> MEASURE.
- MEASURE: watchdog increments each cycle. ready=1 -> capture q_measured, -> EVAL. Watchdog reaches TIMEOUT_CYCLES-1 with ready=0 -> FAULT, err_code=1. Ready and timeout same cycle: ready wins.
- EVAL (one cycle): ctrl_enable=1; diff = |q_des_r - q_meas_r| computed in BUS_WIDTH+1 bits signed, no overflow. diff<=TOL increments in-tolerance counter, else clears it. iter_count increments (saturating). Counter reaches SETTLE_COUNT -> LOCKED. Else iter_count==MAX_ITER -> FAULT, err_code=2. Else -> GAP.
- GAP: wait GAP_CYCLES cycles (0 = straight to START) -> START.
- LOCKED: locked=1, ctrl_enable=0. q_desired != q_des_r -> START next cycle; locked drops that cycle; counters cleared.
- FAULT: err_code held; outputs start/ctrl_enable/locked/busy=0; leaves only via run=0 -> IDLE (err_code cleared on entering IDLE).
- went_unstable=1 in START/MEASURE/EVAL/GAP/LOCKED -> FAULT, err_code=3. Has priority over every other transition except run=0.
- run=0 in any state -> IDLE next cycle; no start/ctrl_enable issued that cycle. Priority: rst > run=0 > went_unstable > timeout/convergence > normal.
- ready outside MEASURE is ignored.
- All outputs registered; start and ctrl_enable high at most one cycle per entry.

Optional Feature:
Macro SEQ_TRACK_EN. Defined: LOCKED re-measures periodically (GAP_CYCLES wait, start pulse, await ready with the same watchdog, no ctrl_enable). Out-of-tolerance result drops locked, clears counters, returns to START. Timeout while tracking -> FAULT err_code=1. Undefined: LOCKED static except q_desired change, went_unstable, run=0.

Decomposition:
- Package meas_seq_pkg: state enum (IDLE, START, MEASURE, EVAL, GAP, LOCKED, FAULT), err_code constants (ERR_NONE, ERR_TIMEOUT, ERR_NOCONV, ERR_UNSTABLE).
- Sub-module seq_watchdog: clear/enable counter with terminal-count flag, parameter TIMEOUT_CYCLES. Reused for GAP wait.

Test Plan:
- Lock: BUS_WIDTH=10, TOL=1, SETTLE_COUNT=4, q_desired=500, ready returns q_measured=499/500/501/500 -> locked=1 after 4th EVAL, iter_count=4, 4 start pulses and 4 ctrl_enable pulses.
- Timeout: TIMEOUT_CYCLES=8, ready never asserted -> FAULT 8 cycles after start, err_code=1; run=0 -> IDLE, err_code=0.
- No convergence: MAX_ITER=5, q_measured always 100 vs q_desired 500 -> err_code=2 after 5th EVAL, no 6th start.
- Instability: went_unstable=1 during GAP -> FAULT err_code=3 next cycle; asserted together with run=0 -> IDLE, err_code=0.
- Retarget: locked at 500, q_desired->300 -> locked=0 and start=1 on the following cycles, counters reset.
- Boundary: ready on the same cycle the watchdog hits terminal count -> EVAL, no fault. rst mid-MEASURE -> all outputs 0 next cycle.
